readout_demux: RTL and testbench
================================

# readout_demux

Receive-side companion to the per-core readout blocks. The core readout blocks time-share a two-bit tristate readout bus (event, polarity), and each core drives the bus in the clock phase after its gray-counter bit toggles. This block rebuilds that slot schedule locally from the same master clock and reset, and samples the bus in every slot. For each captured event it pushes a tagged word (core id, polarity, timestamp) into a small FIFO that off-chip logic drains with a valid/ready handshake.

## Interface
Parameters:
- CNT_W, 19: width of the slot counter. Matches the chip gray counter width.
- N_CORES, 8: number of readout cores. Slots with index ≥ N_CORES are ignored.
- DEPTH, 8: FIFO depth in entries. Must be a power of 2.
- OVF_W, 8: width of the drop counter.

Ports:
- clk_master, in, 1: master clock, shared with the chip gray counter.
- rstb, in, 1: reset, asynchronous, active-low. Same net that resets the chip gray counter.
- readout_iq, in, 2: shared readout bus. [0] = event (out_mux_eve), [1] = polarity (out_mux_pol_eve). The bus may be Z or X between slots.
- out_valid, out, 1: FIFO head is valid.
- out_ready, in, 1: consumer accepts the head.
- out_core, out, 5: core id, 1..N_CORES.
- out_pol, out, 1: event polarity.
- out_ts, out, CNT_W: slot timestamp.
- ovf, out, 1: sticky flag, set on any drop.
- ovf_cnt, out, OVF_W: count of dropped events. Saturates at all-ones.

## Operation
- Binary counter `cnt`:
  - Reset value 0.
  - Increments by 1 every posedge of clk_master and wraps mod 2^CNT_W.
  - Mirrors the chip gray counter, where gray = cnt ^ (cnt>>1).
- Slot decode at the posedge where cnt goes from v to v+1:
  - slot = number of trailing ones of v, clamped to CNT_W-1. At wrap (v all ones) the MSB flips, so slot = CNT_W-1.
  - Core id = slot+1.
  - The slot is active only if slot < N_CORES.
  - The slot id and ts = v+1 are registered for the following high phase.
- Capture:
  - On the negedge of clk_master, sample readout_iq into cap_eve and cap_pol.
  - Any non-1 value (0, Z, X) counts as 0. RTL compares with === 1'b1.
- Push: on the next posedge, if the slot is active and cap_eve = 1, push {core, cap_pol, ts}. Slots with cap_eve = 0 push nothing.
- FIFO:
  - Circular buffer of DEPTH entries with registered head outputs.
  - A pop occurs when out_valid & out_ready at a posedge.
  - When full, a push in the same cycle as a pop is accepted.
  - When full with no pop, the push is dropped: ovf is set and ovf_cnt increments (saturating).
  - When empty, a push is visible on out_* after that posedge.
- out_core, out_pol and out_ts hold their values while out_valid = 0. Their contents are don't-care in that state, but they must not be X after reset.
- No state machine beyond the counter, the capture stage and the FIFO. Pointers are log2(DEPTH)+1 bits so full and empty can be distinguished.

## Timing
- Reset (rstb low) values:
  - cnt = 0, FIFO empty, out_valid = 0.
  - out_core = 0, out_pol = 0, out_ts = 0.
  - ovf = 0, ovf_cnt = 0.
  - Capture and slot registers = 0. The slot is inactive.
- Reset asserted mid-operation: all state clears immediately and asynchronously, and in-flight entries are lost.
- After rstb release, the first posedge gives v = 0 → slot 0 (core 1), ts = 1. The bus is sampled on the following negedge.
- Latency: bus sample on negedge N → out_valid at the next posedge, if the FIFO was empty and no older entries are queued. Minimum latency is half a clock period.
- Slot cadence: core k is active every 2^k cycles.
  - Core 1 at ts = 1, 3, 5…
  - Core 2 at ts = 2, 6, 10…
  - Core 3 at ts = 4, 12, 20…
- Events within a core are in timestamp order. Output order across all cores is FIFO push order.

## Test plan
- Event on every core-1 slot, pol = 0, out_ready = 1 → out_core = 1, ts = 1, 3, 5, 7. There are no pushes from other slots. out_valid pulses for one cycle per event.
- Core-2 slots driven with pol = 1, core-3 slots with pol = 0, other slots undriven (Z) → outputs in order:
  - (2,1,2), (3,0,4), (2,1,6), (2,1,10), (3,0,12).
  - Z slots produce no entries.
- out_ready = 0, event on every core-1 slot → 8 entries with ts = 1..15 (odd). ts = 17 is dropped: ovf = 1, ovf_cnt = 1. Raise out_ready → 8 pops in order, ts 1..15.
- FIFO full while out_ready is held at 1 during a push cycle → simultaneous push and pop. Occupancy stays at 8, with no drop and no ovf.
- Sustained overflow with 300 drops → ovf_cnt saturates at 255 and ovf stays 1.
- Pull rstb low for 3 ns during a queued burst → out_valid = 0, ovf_cnt = 0 and cnt = 0 immediately. After release, the first core-1 event has ts = 1.
- CNT_W = 4 wrap check: v = 15 → slot 3 (core 4), ts = 0. The next slot is core 1 with ts = 1.

Source files
------------

// File: rtl/readout_demux.sv
// Receive side of the time-shared readout bus: rebuilds the per-core slot schedule
// from the master clock, captures events on the falling edge and queues tagged words.
module readout_demux #(
    parameter int CNT_W   = 19,
    parameter int N_CORES = 8,
    parameter int DEPTH   = 8,
    parameter int OVF_W   = 8
) (
    input  logic             clk_master,
    input  logic             rstb,
    input  logic [1:0]       readout_iq,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_core,
    output logic             out_pol,
    output logic [CNT_W-1:0] out_ts,
    output logic             ovf,
    output logic [OVF_W-1:0] ovf_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = 5 + 1 + CNT_W;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       slot_q, slot_d;
    logic             active_q, active_d;
    logic [CNT_W-1:0] ts_q;
    logic             cap_eve_q, cap_pol_q;
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [EW-1:0]    head_q, head_d;
    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    push_data;
    logic             ovf_q, ovf_d;
    logic [OVF_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic             push, push_ok, pop, drop, empty, full, run;

    assign cnt_d = cnt_q + 1'b1;

    // The slot owner is the gray bit that toggles on this increment: trailing ones of v.
    always_comb begin
        slot_d = '0;
        run    = 1'b1;
        for (int i = 0; i < CNT_W - 1; i++) begin
            if (run && cnt_q[i]) begin
                slot_d = 5'(i + 1);
            end else begin
                run = 1'b0;
            end
        end
        active_d = int'(slot_d) < N_CORES;
    end

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            cnt_q    <= '0;
            slot_q   <= '0;
            active_q <= 1'b0;
            ts_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            slot_q   <= slot_d;
            active_q <= active_d;
            ts_q     <= cnt_d;
        end
    end

    // Bus is only driven mid-slot; anything but a clean 1 (including Z/X) means no event.
    always_ff @(negedge clk_master or negedge rstb) begin
        if (!rstb) begin
            cap_eve_q <= 1'b0;
            cap_pol_q <= 1'b0;
        end else begin
            cap_eve_q <= (readout_iq[0] === 1'b1);
            cap_pol_q <= (readout_iq[1] === 1'b1);
        end
    end

    assign push_data = {slot_q + 5'd1, cap_pol_q, ts_q};
    assign push      = active_q & cap_eve_q;
    assign empty     = (wr_q == rd_q);
    assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign out_valid = !empty;
    assign pop       = out_valid & out_ready;
    assign push_ok   = push & (~full | pop);
    assign drop      = push & full & ~pop;

    // Head register preloads whichever entry will sit at rd after this edge,
    // bypassing the memory when that entry is the one being written now.
    always_comb begin
        wr_d      = wr_q + PW'(push_ok);
        rd_d      = rd_q + PW'(pop);
        head_d    = head_q;
        ovf_d     = ovf_q | drop;
        ovf_cnt_d = ovf_cnt_q;
        if (rd_d != wr_d) begin
            head_d = (push_ok && (rd_d == wr_q)) ? push_data : mem[rd_d[AW-1:0]];
        end
        if (drop && (ovf_cnt_q != {OVF_W{1'b1}})) begin
            ovf_cnt_d = ovf_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_master) begin
        if (push_ok) begin
            mem[wr_q[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            wr_q      <= '0;
            rd_q      <= '0;
            head_q    <= '0;
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            head_q    <= head_d;
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign out_core = head_q[EW-1 -: 5];
    assign out_pol  = head_q[CNT_W];
    assign out_ts   = head_q[CNT_W-1:0];
    assign ovf      = ovf_q;
    assign ovf_cnt  = ovf_cnt_q;

endmodule

// File: tb/tb_readout_demux.sv
// Scoreboard bench for readout_demux: stimulus queues expected words, negedge monitors
// pop and compare whenever the DUT hands over a head entry.
module tb_readout_demux;

    localparam int M_IDLE  = 0;
    localparam int M_CORE1 = 1;
    localparam int M_PAT   = 2;
    localparam int M_ALL   = 3;
    localparam int M_HIGH  = 4;

    logic        clk = 1'b0;
    logic        rstb;
    logic [1:0]  bus;
    logic        ready;
    logic        valid;
    logic [4:0]  core;
    logic        pol;
    logic [18:0] ts;
    logic        ovf;
    logic [7:0]  ovfCnt;

    logic        validW;
    logic [4:0]  coreW;
    logic        polW;
    logic [3:0]  tsW;
    logic        ovfW;
    logic [7:0]  ovfCntW;

    int          total = 0;
    int          bad = 0;
    int          tbTs = 0;
    bit          wrapOn = 1'b0;
    logic [24:0] q[$];
    logic [9:0]  q2[$];
    logic [24:0] monExp;
    logic [9:0]  monExp2;
    int          coreTbl[17] = '{1, 2, 1, 3, 1, 2, 1, 4, 1, 2, 1, 3, 1, 2, 1, 4, 1};

    always #5 clk = ~clk;

    readout_demux dut (
        .clk_master(clk), .rstb(rstb), .readout_iq(bus),
        .out_valid(valid), .out_ready(ready), .out_core(core), .out_pol(pol),
        .out_ts(ts), .ovf(ovf), .ovf_cnt(ovfCnt)
    );

    readout_demux #(.CNT_W(4)) dutW (
        .clk_master(clk), .rstb(rstb), .readout_iq(2'b01),
        .out_valid(validW), .out_ready(1'b1), .out_core(coreW), .out_pol(polW),
        .out_ts(tsW), .ovf(ovfW), .ovf_cnt(ovfCntW)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Core k owns the slots whose timestamp has exactly k-1 trailing zeros.
    function automatic int coreOf(input int t);
        int c = 1;
        int v = t;
        if (v == 0) return 99;
        while (v % 2 == 0) begin
            c++;
            v = v / 2;
        end
        return c;
    endfunction

    task automatic applyStimulus(input int n, input int mode, input int expLimit);
        for (int i = 0; i < n; i++) begin
            int   c;
            logic e;
            logic p;
            @(posedge clk); #1;
            tbTs++;
            c = coreOf(tbTs);
            e = 1'b0;
            p = 1'b0;
            case (mode)
                M_CORE1: e = (c == 1);
                M_PAT: begin
                    if (c == 2) begin e = 1'b1; p = 1'b1; end
                    else if (c == 3) e = 1'b1;
                end
                M_ALL:  e = 1'b1;
                M_HIGH: e = (c > 8);
                default: e = 1'b0;
            endcase
            if (mode == M_PAT && !e) bus = 2'bzz;
            else bus = {p, e};
            if (e && c <= 8 && tbTs <= expLimit) q.push_back({5'(c), p, 19'(tbTs)});
        end
        @(posedge clk); #1;
        tbTs++;
        bus = 2'b00;
    endtask

    task automatic doReset();
        @(posedge clk); #2;
        rstb = 1'b0;
        bus = 2'b00;
        q.delete();
        q2.delete();
        #1;
        checkOutput("rst_valid", 32'(valid), 0);
        checkOutput("rst_core", 32'(core), 0);
        checkOutput("rst_pol", 32'(pol), 0);
        checkOutput("rst_ts", 32'(ts), 0);
        checkOutput("rst_ovf", 32'(ovf), 0);
        checkOutput("rst_ovfcnt", 32'(ovfCnt), 0);
        checkOutput("rst_cnt", 32'(dut.cnt_q), 0);
        @(posedge clk); #3;
        rstb = 1'b1;
        tbTs = 0;
    endtask

    task automatic waitDrain(input string name, input int budget);
        for (int i = 0; i < budget && q.size() > 0; i++) @(negedge clk);
        #1;
        checkOutput(name, 32'(q.size()), 0);
        q.delete();
    endtask

    always @(negedge clk) begin
        if (rstb && valid && ready) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_out: got core=%0d pol=%0d ts=%0d expected nothing", core, pol, ts);
            end else begin
                monExp = q.pop_front();
                if ({core, pol, ts} !== monExp) begin
                    bad++;
                    $display("[TB] FAIL out_word: got core=%0d pol=%0d ts=%0d expected core=%0d pol=%0d ts=%0d",
                             core, pol, ts, monExp[24:20], monExp[19], monExp[18:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rstb && wrapOn && validW && q2.size() > 0) begin
            total++;
            monExp2 = q2.pop_front();
            if ({coreW, polW, tsW} !== monExp2) begin
                bad++;
                $display("[TB] FAIL wrap_word: got core=%0d pol=%0d ts=%0d expected core=%0d pol=%0d ts=%0d",
                         coreW, polW, tsW, monExp2[9:5], monExp2[4], monExp2[3:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstb = 1'b0;
        bus = 2'b00;
        ready = 1'b1;
        doReset();

        // Core-1 slots only, consumer always ready
        applyStimulus(7, M_CORE1, 1000);
        waitDrain("drain_core1", 50);

        // Cores 2 and 3 with Z elsewhere
        doReset();
        applyStimulus(12, M_PAT, 1000);
        waitDrain("drain_pattern", 50);

        // Fill with consumer stalled, then one drop
        doReset();
        ready = 1'b0;
        applyStimulus(17, M_CORE1, 15);
        checkOutput("ovf_after_drop", 32'(ovf), 1);
        checkOutput("ovfcnt_after_drop", 32'(ovfCnt), 1);
        ready = 1'b1;
        waitDrain("drain_full", 50);
        checkOutput("ovf_sticky", 32'(ovf), 1);

        // Full FIFO, push and pop on the same edge
        doReset();
        ready = 1'b0;
        applyStimulus(15, M_CORE1, 1000);
        @(posedge clk); #1;
        tbTs++;
        bus = 2'b01;
        ready = 1'b1;
        q.push_back({5'd1, 1'b0, 19'(tbTs)});
        @(posedge clk); #1;
        tbTs++;
        ready = 1'b0;
        bus = 2'b00;
        checkOutput("simul_ovf", 32'(ovf), 0);
        checkOutput("simul_ovfcnt", 32'(ovfCnt), 0);
        checkOutput("simul_occupancy", 32'(4'(dut.wr_q - dut.rd_q)), 8);
        ready = 1'b1;
        waitDrain("drain_simul", 50);

        // Sustained overflow up to saturation
        doReset();
        ready = 1'b0;
        applyStimulus(100, M_ALL, 8);
        checkOutput("ovfcnt_mid", 32'(ovfCnt), 92);
        applyStimulus(220, M_ALL, 8);
        checkOutput("ovfcnt_sat", 32'(ovfCnt), 255);
        checkOutput("ovf_sat", 32'(ovf), 1);
        ready = 1'b1;
        waitDrain("drain_sat", 50);

        // Asynchronous reset in the middle of a queued burst
        doReset();
        ready = 1'b0;
        applyStimulus(19, M_CORE1, 15);
        checkOutput("ovfcnt_prereset", 32'(ovfCnt), 2);
        @(posedge clk); #1;
        rstb = 1'b0;
        q.delete();
        #1;
        checkOutput("midrst_valid", 32'(valid), 0);
        checkOutput("midrst_ovfcnt", 32'(ovfCnt), 0);
        checkOutput("midrst_ovf", 32'(ovf), 0);
        checkOutput("midrst_cnt", 32'(dut.cnt_q), 0);
        #2;
        rstb = 1'b1;
        tbTs = 0;
        ready = 1'b1;
        applyStimulus(3, M_CORE1, 1000);
        waitDrain("drain_postreset", 50);

        // Slots beyond N_CORES are ignored
        doReset();
        ready = 1'b1;
        applyStimulus(260, M_HIGH, 0);
        checkOutput("high_valid", 32'(valid), 0);
        checkOutput("high_ovf", 32'(ovf), 0);

        // Narrow counter wraps into the clamped top slot
        doReset();
        wrapOn = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
            q2.push_back({5'(coreTbl[i]), 1'b0, 4'((i + 1) % 16)});
        end
        for (int i = 0; i < 50 && q2.size() > 0; i++) @(negedge clk);
        #1;
        checkOutput("drain_wrap", 32'(q2.size()), 0);
        checkOutput("wrap_ovf", 32'(ovfW), 0);
        checkOutput("wrap_ovfcnt", 32'(ovfCntW), 0);
        wrapOn = 1'b0;
        q2.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
